// File: rtl/regfile_ar.sv
// 32 x WIDTH register file: two combinational read ports, one clocked write port,
// asynchronous active-high reset. r0 is hardwired to zero.
module regfile_ar #(
  parameter int WIDTH = 32,
  parameter int NREGS = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  output logic [WIDTH-1:0] ReadData1,
  output logic [WIDTH-1:0] ReadData2,
  input  logic [WIDTH-1:0] WriteData,
  input  logic [4:0]       ReadRegister1,
  input  logic [4:0]       ReadRegister2,
  input  logic [4:0]       WriteRegister,
  input  logic             RegWrite
);

  if (NREGS != 32) begin : g_bad_nregs
    $error("regfile_ar: NREGS must be 32 to match the 5-bit address ports");
  end

  logic [NREGS-1:0] write_en;
  logic [WIDTH-1:0] regs_d [NREGS];
  logic [WIDTH-1:0] regs_q [NREGS];

  // One-hot write decoder; bit 0 never asserts so r0 stays zero.
  always_comb begin
    write_en = '0;
    for (int i = 1; i < NREGS; i++) begin
      write_en[i] = RegWrite && (WriteRegister == 5'(i));
    end
  end

  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
      if (write_en[i]) begin
        regs_d[i] = WriteData;
      end
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Reads see stored state only: a same-address write shows up after the edge.
  assign ReadData1 = regs_q[ReadRegister1];
  assign ReadData2 = regs_q[ReadRegister2];

endmodule

// File: tb/tb_regfile_ar.sv
// Directed self-checking bench for regfile_ar: reset, decode, r0, read-during-write,
// back-to-back writes, full address sweep and mid-operation reset.
module tb_regfile_ar;

  localparam int WIDTH = 32;

  logic             Clk;
  logic             Reset;
  logic [WIDTH-1:0] ReadData1;
  logic [WIDTH-1:0] ReadData2;
  logic [WIDTH-1:0] WriteData;
  logic [4:0]       ReadRegister1;
  logic [4:0]       ReadRegister2;
  logic [4:0]       WriteRegister;
  logic             RegWrite;

  int checks;
  int errors;

  regfile_ar #(.WIDTH(WIDTH), .NREGS(32)) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2),
    .WriteData     (WriteData),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .WriteRegister (WriteRegister),
    .RegWrite      (RegWrite)
  );

  // Clock / reset block
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Driver: one write pulse, returns on the falling edge after the write edge.
  task automatic write_reg(input logic [4:0] addr, input logic [WIDTH-1:0] data);
    @(negedge Clk);
    RegWrite      = 1'b1;
    WriteRegister = addr;
    WriteData     = data;
    @(negedge Clk);
    RegWrite      = 1'b0;
  endtask

  task automatic test_reset();
    logic [4:0] addrs [4];
    addrs = '{5'd0, 5'd1, 5'd5, 5'd31};
    RegWrite      = 1'b1;
    WriteRegister = 5'd5;
    WriteData     = 32'hFFFF_FFFF;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    foreach (addrs[k]) begin
      ReadRegister1 = addrs[k];
      ReadRegister2 = addrs[k];
      #1;
      checks++;
      if (ReadData1 !== 32'h0 || ReadData2 !== 32'h0) begin
        errors++;
        $display("FAIL reset_read r%0d: got %h/%h expected 00000000", addrs[k], ReadData1, ReadData2);
      end
    end
    @(negedge Clk);
    RegWrite = 1'b0;
    Reset    = 1'b0;
    ReadRegister1 = 5'd5;
    ReadRegister2 = 5'd5;
    #1;
    checks++;
    if (ReadData1 !== 32'h0 || ReadData2 !== 32'h0) begin
      errors++;
      $display("FAIL reset_release r5: got %h/%h expected 00000000", ReadData1, ReadData2);
    end
  endtask

  task automatic test_decoder();
    write_reg(5'd17, 32'hDEAD_BEEF);
    ReadRegister1 = 5'd16;
    ReadRegister2 = 5'd18;
    #1;
    checks++;
    if (ReadData1 !== 32'h0 || ReadData2 !== 32'h0) begin
      errors++;
      $display("FAIL decoder_neighbours r16/r18: got %h/%h expected 00000000/00000000", ReadData1, ReadData2);
    end
    ReadRegister1 = 5'd17;
    ReadRegister2 = 5'd17;
    #1;
    checks++;
    if (ReadData1 !== 32'hDEAD_BEEF || ReadData2 !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL decoder_target r17: got %h/%h expected deadbeef", ReadData1, ReadData2);
    end
  endtask

  task automatic test_basic_write();
    ReadRegister1 = 5'd2;
    ReadRegister2 = 5'd2;
    write_reg(5'd2, 32'd42);
    #1;
    checks++;
    if (ReadData1 !== 32'd42 || ReadData2 !== 32'd42) begin
      errors++;
      $display("FAIL write_42 r2: got %0d/%0d expected 42", ReadData1, ReadData2);
    end
    write_reg(5'd2, 32'd15);
    #1;
    checks++;
    if (ReadData1 !== 32'd15 || ReadData2 !== 32'd15) begin
      errors++;
      $display("FAIL write_15 r2: got %0d/%0d expected 15", ReadData1, ReadData2);
    end
    @(negedge Clk);
    RegWrite      = 1'b0;
    WriteRegister = 5'd2;
    WriteData     = 32'd99;
    @(negedge Clk);
    #1;
    checks++;
    if (ReadData1 !== 32'd15 || ReadData2 !== 32'd15) begin
      errors++;
      $display("FAIL write_disabled r2: got %0d/%0d expected 15", ReadData1, ReadData2);
    end
  endtask

  task automatic test_r0();
    write_reg(5'd0, 32'hFFFF_FFFF);
    ReadRegister1 = 5'd0;
    ReadRegister2 = 5'd0;
    #1;
    checks++;
    if (ReadData1 !== 32'h0 || ReadData2 !== 32'h0) begin
      errors++;
      $display("FAIL r0_zero: got %h/%h expected 00000000", ReadData1, ReadData2);
    end
  endtask

  task automatic test_read_during_write();
    write_reg(5'd3, 32'h0000_0011);
    @(negedge Clk);
    RegWrite      = 1'b1;
    WriteRegister = 5'd3;
    WriteData     = 32'h0000_0022;
    ReadRegister1 = 5'd3;
    ReadRegister2 = 5'd3;
    #1;
    checks++;
    if (ReadData1 !== 32'h11 || ReadData2 !== 32'h11) begin
      errors++;
      $display("FAIL rdw_before_edge r3: got %h/%h expected 00000011", ReadData1, ReadData2);
    end
    @(posedge Clk);
    #1;
    checks++;
    if (ReadData1 !== 32'h22 || ReadData2 !== 32'h22) begin
      errors++;
      $display("FAIL rdw_after_edge r3: got %h/%h expected 00000022", ReadData1, ReadData2);
    end
    @(negedge Clk);
    RegWrite = 1'b0;
  endtask

  task automatic test_back_to_back();
    ReadRegister1 = 5'd4;
    ReadRegister2 = 5'd4;
    @(negedge Clk);
    RegWrite      = 1'b1;
    WriteRegister = 5'd4;
    WriteData     = 32'hAAAA_0001;
    @(negedge Clk);
    checks++;
    if (ReadData1 !== 32'hAAAA_0001) begin
      errors++;
      $display("FAIL b2b_first r4: got %h expected aaaa0001", ReadData1);
    end
    WriteData = 32'hBBBB_0002;
    @(negedge Clk);
    RegWrite = 1'b0;
    #1;
    checks++;
    if (ReadData1 !== 32'hBBBB_0002 || ReadData2 !== 32'hBBBB_0002) begin
      errors++;
      $display("FAIL b2b_last r4: got %h/%h expected bbbb0002", ReadData1, ReadData2);
    end
  endtask

  task automatic test_addr_change();
    logic [4:0]       a1 [4];
    logic [4:0]       a2 [4];
    logic [WIDTH-1:0] e1 [4];
    logic [WIDTH-1:0] e2 [4];
    a1 = '{5'd2, 5'd17, 5'd4, 5'd3};
    e1 = '{32'd15, 32'hDEAD_BEEF, 32'hBBBB_0002, 32'h22};
    a2 = '{5'd3, 5'd0, 5'd2, 5'd17};
    e2 = '{32'h22, 32'h0, 32'd15, 32'hDEAD_BEEF};
    @(negedge Clk);
    RegWrite = 1'b0;
    foreach (a1[k]) begin
      ReadRegister1 = a1[k];
      ReadRegister2 = a2[k];
      #1;
      checks++;
      if (ReadData1 !== e1[k] || ReadData2 !== e2[k]) begin
        errors++;
        $display("FAIL addr_change r%0d/r%0d: got %h/%h expected %h/%h",
                 a1[k], a2[k], ReadData1, ReadData2, e1[k], e2[k]);
      end
    end
  endtask

  task automatic test_full_range();
    for (int i = 1; i < 32; i++) begin
      write_reg(5'(i), 32'(i * 3));
    end
    for (int i = 1; i < 32; i++) begin
      ReadRegister1 = 5'(i);
      ReadRegister2 = 5'(i);
      #1;
      checks++;
      if (ReadData1 !== 32'(i * 3) || ReadData2 !== 32'(i * 3)) begin
        errors++;
        $display("FAIL full_range r%0d: got %0d/%0d expected %0d", i, ReadData1, ReadData2, i * 3);
      end
    end
  endtask

  task automatic test_reset_mid();
    write_reg(5'd5, 32'd7);
    ReadRegister1 = 5'd5;
    ReadRegister2 = 5'd5;
    #1;
    checks++;
    if (ReadData1 !== 32'd7) begin
      errors++;
      $display("FAIL mid_pre r5: got %0d expected 7", ReadData1);
    end
    #1;
    Reset = 1'b1;
    #1;
    checks++;
    if (ReadData1 !== 32'h0 || ReadData2 !== 32'h0) begin
      errors++;
      $display("FAIL mid_async_clear r5: got %0d/%0d expected 0", ReadData1, ReadData2);
    end
    ReadRegister2 = 5'd31;
    #1;
    checks++;
    if (ReadData2 !== 32'h0) begin
      errors++;
      $display("FAIL mid_async_clear r31: got %0d expected 0", ReadData2);
    end
    RegWrite      = 1'b1;
    WriteRegister = 5'd5;
    WriteData     = 32'd9;
    @(posedge Clk);
    #1;
    checks++;
    if (ReadData1 !== 32'h0) begin
      errors++;
      $display("FAIL mid_write_ignored r5: got %0d expected 0", ReadData1);
    end
    @(negedge Clk);
    RegWrite = 1'b0;
    Reset    = 1'b0;
    #1;
    checks++;
    if (ReadData1 !== 32'h0 || ReadData2 !== 32'h0) begin
      errors++;
      $display("FAIL mid_release r5/r31: got %0d/%0d expected 0/0", ReadData1, ReadData2);
    end
    write_reg(5'd5, 32'd9);
    ReadRegister2 = 5'd5;
    #1;
    checks++;
    if (ReadData1 !== 32'd9 || ReadData2 !== 32'd9) begin
      errors++;
      $display("FAIL mid_rewrite r5: got %0d/%0d expected 9", ReadData1, ReadData2);
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    Reset         = 1'b1;
    RegWrite      = 1'b0;
    WriteData     = '0;
    WriteRegister = '0;
    ReadRegister1 = '0;
    ReadRegister2 = '0;

    test_reset();
    test_decoder();
    test_basic_write();
    test_r0();
    test_read_during_write();
    test_back_to_back();
    test_addr_change();
    test_full_range();
    test_reset_mid();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
